// File: rtl/fifo_rd_stream_if.sv
// Read-side bundle between the dual-clock FIFO read port and the downstream stream.
// The master side is the fifo_rd_stream stage; the slave side is its environment.
interface fifo_rd_stream_if #(
  parameter int WIDTH = 8
);
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_pop;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  out_ready,
    output fifo_pop,
    output out_data,
    output out_valid
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output out_ready,
    input  fifo_pop,
    input  out_data,
    input  out_valid
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// FIFO read port to valid/ready stream adapter with a 2-entry skid buffer and flush.
// Optional word/stall counters are enabled by defining FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream #(
  parameter int WIDTH = 8
) (
  input  logic              rdclk,
  input  logic              rd_rst,
  input  logic              flush,
  fifo_rd_stream_if.master  bus,
  output logic [1:0]        level
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]       word_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  logic [1:0]       occ;
  logic             inflight;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [WIDTH-1:0] mem [2];

  logic             valid;
  logic             acc;
  logic             pop;
  logic [2:0]       credit;

  // A pop is allowed only if the word it returns is guaranteed a free slot.
  always_comb begin
    valid  = (occ != 2'd0);
    acc    = valid && bus.out_ready;
    credit = {1'b0, occ} + {2'b00, inflight} - {2'b00, acc};
    pop    = !bus.fifo_empty && !flush && !rd_rst && (credit < 3'd2);
  end

  assign bus.fifo_pop  = pop;
  assign bus.out_valid = valid;
  assign bus.out_data  = mem[rd_ptr];
  assign level         = occ;

  always_ff @(posedge rdclk) begin
    if (rd_rst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else if (flush) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
    end else begin
      inflight <= pop;
      if (inflight) begin
        mem[wr_ptr] <= bus.fifo_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (acc) begin
        rd_ptr <= ~rd_ptr;
      end
      occ <= occ + {1'b0, inflight} - {1'b0, acc};
    end
  end

  // The credit rule must never let a returning word land on a full buffer.
  no_capture_when_full: assert property (
    @(posedge rdclk) disable iff (rd_rst) !(inflight && occ == 2'd2)
  );

`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge rdclk) begin
    if (rd_rst) begin
      word_cnt  <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (acc) begin
        word_cnt <= word_cnt + 32'd1;
      end
      if (valid && !bus.out_ready) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed and random bench for fifo_rd_stream against a queue-based reference model.
module tb_fifo_rd_stream;

  logic       rdclk = 1'b0;
  logic       rd_rst;
  logic       flush;
  logic [1:0] level;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] word_cnt;
  logic [31:0] stall_cnt;
  logic [31:0] m_word_cnt;
  logic [31:0] m_stall_cnt;
`endif

  always #5 rdclk = ~rdclk;

  fifo_rd_stream_if #(.WIDTH(8)) bus ();

  fifo_rd_stream #(.WIDTH(8)) dut (
    .rdclk (rdclk),
    .rd_rst(rd_rst),
    .flush (flush),
    .bus   (bus.master),
    .level (level)
`ifdef FIFO_RD_STREAM_STATS_EN
    ,
    .word_cnt (word_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] src[$];
  logic [7:0] held[$];
  logic [7:0] got[$];
  logic [7:0] exp_words[$];
  int         m_flight;
  logic [7:0] m_flight_word;

  bit   check_en;
  logic s_rst, s_flush, s_exp_pop, s_exp_acc, s_dut_pop, s_valid, s_ready;
  int   cyc, pop_cnt, first_pop_cyc, first_valid_cyc, gap_cnt, gap_target, max_level;
  bit   track_gaps;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected outputs come from the held-word queue and the pop credit rule.
  task automatic checkOutput();
    logic exp_valid, exp_acc, exp_pop;
    int   proj;
    exp_valid = (held.size() != 0);
    exp_acc   = exp_valid && bus.out_ready;
    proj      = held.size() + m_flight - (exp_acc ? 1 : 0);
    exp_pop   = !bus.fifo_empty && !flush && !rd_rst && (proj < 2);
    if (check_en) begin
      check("fifo_pop", {31'd0, bus.fifo_pop}, {31'd0, exp_pop});
      check("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_valid});
      check("level", {30'd0, level}, held.size());
      check("no_underrun", {31'd0, bus.fifo_pop && bus.fifo_empty}, 32'd0);
      if (exp_valid) check("out_data", {24'd0, bus.out_data}, {24'd0, held[0]});
      if (s_rst) check("rst_out_data", {24'd0, bus.out_data}, 32'd0);
`ifdef FIFO_RD_STREAM_STATS_EN
      check("word_cnt", word_cnt, m_word_cnt);
      check("stall_cnt", stall_cnt, m_stall_cnt);
`endif
    end
    if (track_gaps && got.size() > 0 && got.size() < gap_target && bus.out_valid !== 1'b1)
      gap_cnt++;
    if (bus.out_valid === 1'b1 && bus.out_ready) got.push_back(bus.out_data);
    if (bus.fifo_pop === 1'b1) begin
      pop_cnt++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
    end
    if (bus.out_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (int'(level) > max_level) max_level = int'(level);
    s_rst     = rd_rst;
    s_flush   = flush;
    s_exp_pop = exp_pop;
    s_exp_acc = exp_acc;
    s_dut_pop = bus.fifo_pop;
    s_valid   = exp_valid;
    s_ready   = bus.out_ready;
  endtask

  task automatic tick();
    @(posedge rdclk);
    #1;
    cyc++;
    if (s_rst || s_flush) begin
      held.delete();
      m_flight = 0;
    end else begin
      if (s_exp_acc) void'(held.pop_front());
      if (m_flight != 0) held.push_back(m_flight_word);
      m_flight = s_exp_pop ? 1 : 0;
    end
`ifdef FIFO_RD_STREAM_STATS_EN
    if (s_rst) begin
      m_word_cnt  = 32'd0;
      m_stall_cnt = 32'd0;
    end else begin
      if (s_exp_acc) m_word_cnt++;
      if (s_valid && !s_ready) m_stall_cnt++;
    end
`endif
    // FIFO read port: data appears the cycle after an accepted pop.
    if (s_dut_pop === 1'b1 && src.size() > 0) bus.fifo_data = src.pop_front();
    m_flight_word = bus.fifo_data;
  endtask

  task automatic applyStimulus(input logic r, input logic f, input logic rdy);
    rd_rst         = r;
    flush          = f;
    bus.out_ready  = rdy;
    bus.fifo_empty = (src.size() == 0);
    #1;
    checkOutput();
    tick();
  endtask

  task automatic drain(input int n, input bit rnd, input int budget);
    int k = 0;
    while (got.size() < n && k < budget) begin
      applyStimulus(1'b0, 1'b0, rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      k++;
    end
    check("drain_count", got.size(), n);
  endtask

  task automatic clearStats();
    got.delete();
    pop_cnt         = 0;
    first_pop_cyc   = -1;
    first_valid_cyc = -1;
    gap_cnt         = 0;
    track_gaps      = 0;
    gap_target      = 0;
  endtask

  initial begin
    check_en      = 0;
    s_rst         = 0;
    m_flight      = 0;
    m_flight_word = 8'd0;
    cyc           = 0;
    max_level     = 0;
    bus.fifo_data = 8'd0;
    clearStats();

    // Reset with data waiting in the FIFO
    src = '{8'h01, 8'h02, 8'h03};
    applyStimulus(1'b1, 1'b0, 1'b0);
    check_en = 1;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check("reset_level", {30'd0, level}, 32'd0);
    src.delete();
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Streaming 0x01..0x10 with out_ready held high
    clearStats();
    for (int i = 1; i <= 16; i++) src.push_back(8'(i));
    track_gaps = 1;
    gap_target = 16;
    drain(16, 1'b0, 100);
    check("stream_latency", first_valid_cyc - first_pop_cyc, 32'd2);
    check("stream_gaps", gap_cnt, 32'd0);
    for (int i = 0; i < 16 && i < got.size(); i++)
      check("stream_word", {24'd0, got[i]}, i + 1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);

    // Back-pressure: only two words may be pulled while stalled
    clearStats();
    for (int i = 0; i < 6; i++) src.push_back(8'hA0 + 8'(i));
    repeat (6) applyStimulus(1'b0, 1'b0, 1'b0);
    check("bp_pops", pop_cnt, 32'd2);
    check("bp_level", {30'd0, level}, 32'd2);
    check("bp_data", {24'd0, bus.out_data}, 32'hA0);
    track_gaps = 1;
    gap_target = 6;
    drain(6, 1'b0, 50);
    check("bp_gaps", gap_cnt, 32'd0);
    for (int i = 0; i < 6 && i < got.size(); i++)
      check("bp_word", {24'd0, got[i]}, 32'hA0 + i);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);

    // Random ready with 1000 random words
    clearStats();
    exp_words.delete();
    max_level = 0;
    for (int i = 0; i < 1000; i++) begin
      exp_words.push_back(8'($urandom));
      src.push_back(exp_words[i]);
    end
    drain(1000, 1'b1, 5000);
    for (int i = 0; i < 1000 && i < got.size(); i++)
      check("rand_word", {24'd0, got[i]}, {24'd0, exp_words[i]});
    check("rand_level_max", {31'd0, max_level <= 2}, 32'd1);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);

    // Flush with one word held and 0x55 in flight
    clearStats();
    src = '{8'h50, 8'h51, 8'h55, 8'h56};
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    check("fl_level_full", {30'd0, level}, 32'd2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    check("fl_level_pre", {30'd0, level}, 32'd1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    check("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    check("fl_level", {30'd0, level}, 32'd0);
    drain(2, 1'b0, 20);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b1);
    check("fl_total", got.size(), 32'd2);
    if (got.size() >= 2) begin
      check("fl_first", {24'd0, got[0]}, 32'h50);
      check("fl_next", {24'd0, got[1]}, 32'h56);
    end

    // Reset mid-operation, then a single-word FIFO
    clearStats();
    src = '{8'h70, 8'h71, 8'h72};
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    check("mr_level", {30'd0, level}, 32'd0);
    check("mr_data", {24'd0, bus.out_data}, 32'd0);
    src.delete();
    clearStats();
    src = '{8'h3C};
    drain(1, 1'b0, 20);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);
    check("one_pops", pop_cnt, 32'd1);
    check("one_count", got.size(), 32'd1);
    if (got.size() >= 1) check("one_word", {24'd0, got[0]}, 32'h3C);
`ifdef FIFO_RD_STREAM_STATS_EN
    check("one_word_cnt", word_cnt, 32'd1);
    check("one_stall_cnt", stall_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
